// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: scan codes, event-word bit positions,
// direction encoding and the move-key decoder.
package kbd_pkg;

  // Bit positions inside the 11-bit key event word
  localparam int KE_VALID = 10;
  localparam int KE_EXT   = 9;
  localparam int KE_BRK   = 8;

  // Set-2 scan codes (non-extended)
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_G     = 8'h34;

  // Extended (E0-prefixed) arrow codes
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Two-bit signed step encoding
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Returns {is_move, dx, dy}; non-move codes return all zeros
  function automatic logic [4:0] decode_dir(input logic ext, input logic [7:0] code);
    logic [4:0] r;
    r = 5'b0_00_00;
    if (ext) begin
      case (code)
        SC_UP:    r = {1'b1, DIR_NONE, DIR_NEG};
        SC_DOWN:  r = {1'b1, DIR_NONE, DIR_POS};
        SC_LEFT:  r = {1'b1, DIR_NEG,  DIR_NONE};
        SC_RIGHT: r = {1'b1, DIR_POS,  DIR_NONE};
        default:  r = 5'b0_00_00;
      endcase
    end else begin
      case (code)
        SC_Q:    r = {1'b1, DIR_NEG,  DIR_NEG};
        SC_E:    r = {1'b1, DIR_POS,  DIR_NEG};
        SC_Z:    r = {1'b1, DIR_NEG,  DIR_POS};
        SC_C:    r = {1'b1, DIR_POS,  DIR_POS};
        SC_W:    r = {1'b1, DIR_NONE, DIR_NEG};
        SC_X:    r = {1'b1, DIR_NONE, DIR_POS};
        SC_S:    r = {1'b1, DIR_NONE, DIR_POS};
        SC_A:    r = {1'b1, DIR_NEG,  DIR_NONE};
        SC_D:    r = {1'b1, DIR_POS,  DIR_NONE};
        default: r = 5'b0_00_00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis cursor step: applies -1/0/+1 with wrap-around or saturation.
// Uses compare-and-substitute so N need not be a power of two.
module axis_step
  import kbd_pkg::*;
#(
  parameter int N    = 8,
  parameter int WRAP = 1,
  parameter int W    = $clog2(N)
) (
  input  logic [W-1:0] pos,
  input  logic [1:0]   delta,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] MAXP = W'(N - 1);
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  // Next position for a single signed step on this axis
  always_comb begin
    nxt = pos;
    case (delta)
      DIR_POS: begin
        if (pos == MAXP) begin
          nxt = (WRAP != 0) ? ZERO : MAXP;
        end else begin
          nxt = pos + W'(1);
        end
      end
      DIR_NEG: begin
        if (pos == ZERO) begin
          nxt = (WRAP != 0) ? MAXP : ZERO;
        end else begin
          nxt = pos - W'(1);
        end
      end
      default: nxt = pos;
    endcase
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Keyboard-driven board cursor with held-key auto-repeat, freeze and
// one-cycle select / promote / move strobes.
module cursor_ctrl
  import kbd_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int XW           = $clog2(COLS),
  parameter int YW           = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   key_event,
  input  logic          freeze,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          select_pulse,
  output logic          promo_pulse,
  output logic          move_pulse
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LOAD_DELAY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] LOAD_RATE  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

  state_e        state_q, state_d;
  logic [8:0]    held_q, held_d;      // {ext, code} of the held move key, 0 = none
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    prev_q, prev_d;      // last cycle's {ext, brk, code}
  logic [XW-1:0] x_q, x_d, nx;
  logic [YW-1:0] y_q, y_d, ny;
  logic          sel_q, sel_d, pro_q, pro_d, move_q, move_d;

  logic          new_ev, make_ev, brk_ev, ev_is_held, is_sel, is_pro, apply;
  logic [8:0]    ev_key;
  logic [4:0]    ev_dir, held_dir;
  logic [1:0]    mdx, mdy;

  // Event qualification: a level-held word only counts on the cycle it changes
  always_comb begin
    prev_d     = key_event[KE_EXT:0];
    ev_key     = {key_event[KE_EXT], key_event[7:0]};
    new_ev     = key_event[KE_VALID] && (key_event[KE_EXT:0] != prev_q);
    make_ev    = new_ev && !key_event[KE_BRK];
    brk_ev     = new_ev && key_event[KE_BRK];
    ev_is_held = (ev_key == held_q);
    ev_dir     = decode_dir(key_event[KE_EXT], key_event[7:0]);
    held_dir   = decode_dir(held_q[8], held_q[7:0]);
    is_sel     = !key_event[KE_EXT] && (key_event[7:0] == SC_SPACE);
    is_pro     = !key_event[KE_EXT] && (key_event[7:0] == SC_G);
  end

  // Held-key FSM: chooses which step (if any) to apply and drives strobes
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    mdx     = DIR_NONE;
    mdy     = DIR_NONE;
    sel_d   = 1'b0;
    pro_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (make_ev && ev_dir[4]) begin
          held_d  = ev_key;
          cnt_d   = LOAD_DELAY;
          state_d = ST_DELAY;
          apply   = !freeze;
          mdx     = ev_dir[3:2];
          mdy     = ev_dir[1:0];
        end else begin
          sel_d = make_ev && is_sel && !freeze;
          pro_d = make_ev && is_pro && !freeze;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (brk_ev && ev_is_held) begin
          state_d = ST_IDLE;
          held_d  = 9'h000;
          cnt_d   = CNT_ZERO;
        end else if (make_ev && ev_dir[4] && !ev_is_held) begin
          // A different move key takes over; it wins over a coincident expiry
          held_d  = ev_key;
          cnt_d   = LOAD_DELAY;
          state_d = ST_DELAY;
          apply   = !freeze;
          mdx     = ev_dir[3:2];
          mdy     = ev_dir[1:0];
        end else begin
          sel_d = make_ev && is_sel && !freeze;
          pro_d = make_ev && is_pro && !freeze;
          if (freeze) begin
            cnt_d = cnt_q;
          end else if (cnt_q == CNT_ZERO) begin
            cnt_d   = LOAD_RATE;
            state_d = ST_REPEAT;
            apply   = held_dir[4];
            mdx     = held_dir[3:2];
            mdy     = held_dir[1:0];
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        held_d  = 9'h000;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  axis_step #(.N(COLS), .WRAP(WRAP), .W(XW)) u_step_x (.pos(x_q), .delta(mdx), .nxt(nx));
  axis_step #(.N(ROWS), .WRAP(WRAP), .W(YW)) u_step_y (.pos(y_q), .delta(mdy), .nxt(ny));

  // Cursor update; the move strobe fires only on an actual position change
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    move_d = 1'b0;
    if (apply) begin
      x_d    = nx;
      y_d    = ny;
      move_d = (nx != x_q) || (ny != y_q);
    end else begin
      x_d    = x_q;
      y_d    = y_q;
      move_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= 9'h000;
      cnt_q   <= CNT_ZERO;
      prev_q  <= 10'h000;
      x_q     <= {XW{1'b0}};
      y_q     <= {YW{1'b0}};
      sel_q   <= 1'b0;
      pro_q   <= 1'b0;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      pro_q   <= pro_d;
      move_q  <= move_d;
    end
  end

  assign cursor_x     = x_q;
  assign cursor_y     = y_q;
  assign select_pulse = sel_q;
  assign promo_pulse  = pro_q;
  assign move_pulse   = move_q;

endmodule
